// File: rtl/riscv_lsu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// riscv_lsu: load/store unit with a latency-configurable memory handshake.
// It drives the core stall, formats store lanes and extends load data.
// The LSU_MISALIGN_CHECK_EN macro enables rejection of misaligned accesses.
// Revision: 1.0
// ---------------------------------------------------------------------------
module riscv_lsu #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'((MEM_LATENCY >= 2) ? MEM_LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    size_q;
  logic [1:0]    off_q;
  logic          we_q;

  logic        w_misalign;
  logic        w_accept;
  logic        w_active;
  logic [31:0] w_wd_fmt;
  logic [3:0]  w_be_fmt;
  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;
  logic [31:0] w_ext;

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    if (core_size_i[1:0] == 2'b01) begin
      w_misalign = core_addr_i[0];
    end else if (core_size_i[1:0] != 2'b00) begin
      w_misalign = |core_addr_i[1:0];
    end
  end
  assign core_misalign_o = ~rst_i & (state_q == IDLE) & core_req_i & w_misalign;
`else
  assign w_misalign      = 1'b0;
  assign core_misalign_o = 1'b0;
`endif

  assign w_accept = (state_q == IDLE) & core_req_i & ~w_misalign;
  assign w_active = w_accept | (state_q == BUSY);

  // Store lanes come from the live inputs; the core holds them while stalled.
  always_comb begin
    w_wd_fmt = core_wd_i;
    w_be_fmt = 4'b1111;
    case (core_size_i[1:0])
      2'b00: begin
        w_wd_fmt = {4{core_wd_i[7:0]}};
        w_be_fmt = 4'b0001 << core_addr_i[1:0];
      end
      2'b01: begin
        w_wd_fmt = {2{core_wd_i[15:0]}};
        w_be_fmt = 4'b0011 << {core_addr_i[1], 1'b0};
      end
      default: begin
        w_wd_fmt = core_wd_i;
        w_be_fmt = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_lane8  = mem_rd_i[{off_q, 3'b000} +: 8];
    w_lane16 = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q[1:0])
      2'b00:   w_ext = size_q[2] ? {24'd0, w_lane8}  : {{24{w_lane8[7]}}, w_lane8};
      2'b01:   w_ext = size_q[2] ? {16'd0, w_lane16} : {{16{w_lane16[15]}}, w_lane16};
      default: w_ext = mem_rd_i;
    endcase
  end

  assign core_stall_o = ~rst_i & w_active;
  assign mem_req_o    = ~rst_i & w_active;
  assign mem_we_o     = mem_req_o & core_we_i;
  assign mem_be_o     = mem_we_o ? w_be_fmt : 4'b0000;
  assign mem_addr_o   = rst_i ? 32'd0 : {core_addr_i[31:2], 2'b00};
  assign mem_wd_o     = rst_i ? 32'd0 : w_wd_fmt;
  assign core_rd_o    = (~rst_i && state_q == DONE && !we_q) ? w_ext : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_accept) begin
            size_q  <= core_size_i;
            off_q   <= core_addr_i[1:0];
            we_q    <= core_we_i;
            cnt_q   <= '0;
            state_q <= (MEM_LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
          end
        end
        // The core retires on this edge; a still-high request is the same instruction.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
